// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the byte-lane data memory.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Byte-write-enable for a store of the given size at the given lane.
  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << lane;
      SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Store data replicated across lanes; the mask picks the lanes that land.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wd[7:0]}};
      SZ_HALF: d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Pull the addressed lane(s) out of a word and sign/zero extend.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: r = {{24{~uns & sh[7]}}, sh[7:0]};
      SZ_HALF: r = {{16{~uns & sh[15]}}, sh[15:0]};
      SZ_WORD: r = word;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bytelane_be_ram.sv
// Single-port word RAM with per-byte write enables and a registered read.
// No reset so the array and read register map onto block RAM.
module dmem_be_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  // Byte-masked write on stores, registered read on loads.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (we == 4'b0000) rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-addressable data memory: request handshake, alignment check,
// READ_LAT-deep response pipeline and a saturating error counter.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is simply ena, so the requester need not wait on anything else.
// The response side has no ready: rsp_valid pulses for one cycle exactly
// READ_LAT cycles after acceptance, in request order.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int READ_LAT = 1,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  output logic                rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int WAW = ADDR_W - 2;

  logic        accept;
  logic        req_err;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;

  // Stage-1 bookkeeping travelling alongside the RAM read.
  logic                s1_valid_q, s1_valid_d;
  logic                s1_err_q, s1_err_d;
  logic                s1_load_q, s1_load_d;
  logic [1:0]          s1_size_q, s1_size_d;
  logic [1:0]          s1_lane_q, s1_lane_d;
  logic                s1_uns_q, s1_uns_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]         s1_rdata;
  logic                s1_rsp_err;

  assign req_ready = ena;
  assign accept    = req_valid && ena;

  // Alignment / legality check; erroring requests never touch the array.
  always_comb begin
    case (req_size)
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = |req_addr[1:0];
      SZ_ILL:  req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    ram_en = accept && !req_err;
    ram_we = (ram_en && req_we) ? store_mask(req_size, req_addr[1:0]) : 4'b0000;
  end

  dmem_be_ram #(.DEPTH(2**WAW), .AW(WAW)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (req_addr[ADDR_W-1:2]),
    .wdata (store_data(req_size, req_wdata)),
    .rdata (ram_rdata)
  );

  // Next-state for stage 1 and the saturating error counter.
  always_comb begin
    s1_valid_d = accept;
    s1_err_d   = req_err;
    s1_load_d  = !req_we;
    s1_size_d  = req_size;
    s1_lane_d  = req_addr[1:0];
    s1_uns_d   = req_unsigned;
    err_cnt_d  = err_cnt_q;
    if (accept && req_err && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
  end

  // Stage-1 and counter registers; reset drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_load_q  <= 1'b0;
      s1_size_q  <= SZ_BYTE;
      s1_lane_q  <= 2'b00;
      s1_uns_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
      s1_load_q  <= s1_load_d;
      s1_size_q  <= s1_size_d;
      s1_lane_q  <= s1_lane_d;
      s1_uns_q   <= s1_uns_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Stage-1 response: only good loads carry data, everything else reads 0.
  always_comb begin
    s1_rdata   = 32'h0;
    s1_rsp_err = s1_valid_q && s1_err_q;
    if (s1_valid_q && s1_load_q && !s1_err_q)
      s1_rdata = load_extend(ram_rdata, s1_size_q, s1_lane_q, s1_uns_q);
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic        out_valid_q, out_valid_d;
      logic [31:0] out_rdata_q, out_rdata_d;
      logic        out_err_q, out_err_d;

      // Extra output stage carries the stage-1 response one more cycle.
      always_comb begin
        out_valid_d = s1_valid_q;
        out_rdata_d = s1_rdata;
        out_err_d   = s1_rsp_err;
      end

      // Output register stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          out_rdata_q <= 32'h0;
          out_err_q   <= 1'b0;
        end else begin
          out_valid_q <= out_valid_d;
          out_rdata_q <= out_rdata_d;
          out_err_q   <= out_err_d;
        end
      end

      assign rsp_valid = out_valid_q;
      assign rsp_rdata = out_rdata_q;
      assign rsp_err   = out_err_q;
    end else begin : g_lat1
      assign rsp_valid = s1_valid_q;
      assign rsp_rdata = s1_rdata;
      assign rsp_err   = s1_rsp_err;
    end
  endgenerate

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Bench for dmem_bytelane: two instances (READ_LAT=1 / 8-bit counter and
// READ_LAT=2 / 2-bit counter) share one directed stimulus stream.
module tb_dmem_bytelane;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        ena, req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;

  logic        req_ready_a, rsp_valid_a, rsp_err_a;
  logic [31:0] rsp_rdata_a;
  logic [7:0]  err_cnt_a;
  logic        req_ready_b, rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_rdata_b;
  logic [1:0]  err_cnt_b;

  dmem_bytelane #(.ADDR_W(12), .READ_LAT(1), .ERRCNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req_valid(req_valid), .req_ready(req_ready_a),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
    .rsp_err(rsp_err_a), .err_cnt(err_cnt_a));

  dmem_bytelane #(.ADDR_W(12), .READ_LAT(2), .ERRCNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
    .rsp_err(rsp_err_b), .err_cnt(err_cnt_b));

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_mod = 0;
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          exp_cyc_q[$];
  int          hd[2];
  logic [32:0] obs_a[$];
  logic [32:0] obs_b[$];
  int          ba, bb;
  logic [7:0]  bm [4096];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model (byte array) ----------------
  always @(posedge clk) begin
    int n;
    logic bad;
    logic [31:0] v;
    cyc++;
    if (!rst_n) err_mod = 0;
    else if (req_valid && ena) begin
      n   = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
      bad = (req_size == 2'd3) || ((int'(req_addr) % n) != 0);
      v   = 32'h0;
      if (bad) err_mod++;
      else if (req_we) begin
        for (int i = 0; i < n; i++) bm[int'(req_addr) + i] = req_wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) v = v | (32'(bm[int'(req_addr) + i]) << (8*i));
        if (!req_unsigned && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
      end
      exp_q.push_back(v);
      exp_err_q.push_back(bad);
      exp_cyc_q.push_back(cyc);
    end
  end

  task automatic check_port(input int p, input int lat, input logic v, input logic [31:0] d,
                            input logic e, input int cnt, input int cmax, input logic rdy);
    logic ev, ee;
    logic [31:0] ed;
    string s;
    s  = (p == 0) ? "a" : "b";
    ev = (hd[p] < exp_q.size()) && (exp_cyc_q[hd[p]] + lat - 1 == cyc);
    ed = 32'h0;
    ee = 1'b0;
    if (ev) begin
      ed = exp_q[hd[p]];
      ee = exp_err_q[hd[p]];
      hd[p]++;
    end
    chk({"rsp_valid ", s}, 64'(v), 64'(ev));
    chk({"rsp_rdata ", s}, 64'(d), 64'(ed));
    chk({"rsp_err ", s}, 64'(e), 64'(ee));
    chk({"err_cnt ", s}, 64'(cnt), 64'((err_mod > cmax) ? cmax : err_mod));
    chk({"req_ready ", s}, 64'(rdy), 64'(ena));
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset rsp_valid a", 64'(rsp_valid_a), 64'h0);
      chk("reset rsp_valid b", 64'(rsp_valid_b), 64'h0);
      chk("reset rsp_rdata a", 64'(rsp_rdata_a), 64'h0);
      chk("reset rsp_rdata b", 64'(rsp_rdata_b), 64'h0);
      chk("reset rsp_err a", 64'(rsp_err_a | rsp_err_b), 64'h0);
      chk("reset err_cnt", 64'({err_cnt_a, err_cnt_b}), 64'h0);
      hd[0] = exp_q.size();
      hd[1] = exp_q.size();
    end else begin
      check_port(0, 1, rsp_valid_a, rsp_rdata_a, rsp_err_a, int'(err_cnt_a), 255, req_ready_a);
      check_port(1, 2, rsp_valid_b, rsp_rdata_b, rsp_err_b, int'(err_cnt_b), 3, req_ready_b);
      if (rsp_valid_a) obs_a.push_back({rsp_err_a, rsp_rdata_a});
      if (rsp_valid_b) obs_b.push_back({rsp_err_b, rsp_rdata_b});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [11:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic mark();
    ba = obs_a.size();
    bb = obs_b.size();
  endtask

  // Hand-computed literal expectation for the off-th response since mark().
  task automatic lit(input string nm, input int off, input logic [32:0] exp);
    chk({nm, " a"}, 64'(obs_a[ba + off]), 64'(exp));
    chk({nm, " b"}, 64'(obs_b[bb + off]), 64'(exp));
  endtask

  task automatic lit_count(input string nm, input int n);
    chk({nm, " count a"}, 64'(obs_a.size() - ba), 64'(n));
    chk({nm, " count b"}, 64'(obs_b.size() - bb), 64'(n));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int ra, rb;
    hd[0] = 0; hd[1] = 0;
    for (int i = 0; i < 4096; i++) bm[i] = 8'h0;
    rst_n = 1'b0; ena = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // 1: word store then signed / unsigned byte loads
    mark();
    send(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) send(1'b0, 2'b00, 1'b0, 12'h010 + 12'(i), 32'h0);
    for (int i = 0; i < 4; i++) send(1'b0, 2'b00, 1'b1, 12'h010 + 12'(i), 32'h0);
    idle(3);
    lit_count("t1", 9);
    lit("t1 store", 0, 33'h0_00000000);
    lit("t1 sb0", 1, 33'h0_FFFFFFEF);
    lit("t1 sb1", 2, 33'h0_FFFFFFBE);
    lit("t1 sb2", 3, 33'h0_FFFFFFAD);
    lit("t1 sb3", 4, 33'h0_FFFFFFDE);
    lit("t1 ub0", 5, 33'h0_000000EF);
    lit("t1 ub3", 8, 33'h0_000000DE);

    // 2: partial stores merge into an existing word
    mark();
    send(1'b1, 2'b10, 1'b0, 12'h020, 32'h11223344);
    send(1'b1, 2'b01, 1'b0, 12'h022, 32'h0000ABCD);
    send(1'b0, 2'b10, 1'b0, 12'h020, 32'h0);
    send(1'b1, 2'b00, 1'b0, 12'h021, 32'h00000055);
    send(1'b0, 2'b10, 1'b0, 12'h020, 32'h0);
    send(1'b1, 2'b10, 1'b0, 12'h024, 32'hCAFEF00D);
    send(1'b0, 2'b01, 1'b0, 12'h022, 32'h0);
    idle(3);
    lit("t2 word", 2, 33'h0_ABCD3344);
    lit("t2 merged", 4, 33'h0_ABCD5544);
    lit("t2 half signed", 6, 33'h0_FFFFABCD);

    // 3: misaligned and illegal requests, memory untouched, counter saturation
    mark();
    send(1'b0, 2'b01, 1'b0, 12'h021, 32'h0);
    send(1'b1, 2'b10, 1'b0, 12'h026, 32'hFFFFFFFF);
    send(1'b0, 2'b11, 1'b0, 12'h000, 32'h0);
    send(1'b0, 2'b10, 1'b0, 12'h024, 32'h0);
    idle(3);
    lit("t3 half misaligned", 0, 33'h1_00000000);
    lit("t3 word misaligned", 1, 33'h1_00000000);
    lit("t3 size11", 2, 33'h1_00000000);
    lit("t3 unchanged", 3, 33'h0_CAFEF00D);
    chk("t3 err_cnt a", 64'(err_cnt_a), 64'd3);
    chk("t3 err_cnt b", 64'(err_cnt_b), 64'd3);
    send(1'b1, 2'b11, 1'b0, 12'h030, 32'h0);
    idle(3);
    chk("t3 err_cnt a after 4", 64'(err_cnt_a), 64'd4);
    chk("t3 err_cnt b saturated", 64'(err_cnt_b), 64'd3);

    // 4: read-after-write back to back, order preserved
    mark();
    send(1'b1, 2'b10, 1'b0, 12'h040, 32'h12345678);
    send(1'b0, 2'b10, 1'b0, 12'h040, 32'h0);
    send(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    send(1'b0, 2'b01, 1'b1, 12'h042, 32'h0);
    idle(3);
    lit("t4 raw", 1, 33'h0_12345678);
    lit("t4 order", 2, 33'h0_DEADBEEF);
    lit("t4 half unsigned", 3, 33'h0_00001234);

    // 5: ena drop with loads in flight, then a request while disabled
    mark();
    send(1'b0, 2'b10, 1'b0, 12'h020, 32'h0);
    send(1'b0, 2'b10, 1'b0, 12'h040, 32'h0);
    send(1'b0, 2'b10, 1'b0, 12'h024, 32'h0);
    ena = 1'b0;
    #1 chk("t5 req_ready a", 64'(req_ready_a), 64'h0);
    chk("t5 req_ready b", 64'(req_ready_b), 64'h0);
    req_we = 1'b1; req_addr = 12'h040; req_wdata = 32'h0BADF00D;
    repeat (4) begin @(negedge clk); #1; end
    lit_count("t5", 3);
    lit("t5 l0", 0, 33'h0_ABCD5544);
    lit("t5 l1", 1, 33'h0_12345678);
    lit("t5 l2", 2, 33'h0_CAFEF00D);
    req_valid = 1'b0; ena = 1'b1;
    idle(2);

    // 6: reset with loads in flight drops them, memory survives
    send(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    send(1'b0, 2'b10, 1'b0, 12'h040, 32'h0);
    req_valid = 1'b0;
    ra = obs_a.size(); rb = obs_b.size();
    rst_n = 1'b0;
    #1 chk("t6 rsp_valid a falls", 64'(rsp_valid_a), 64'h0);
    chk("t6 rsp_valid b falls", 64'(rsp_valid_b), 64'h0);
    chk("t6 err_cnt a", 64'(err_cnt_a), 64'h0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst_n = 1'b1;
    idle(4);
    chk("t6 no stale a", 64'(obs_a.size()), 64'(ra));
    chk("t6 no stale b", 64'(obs_b.size()), 64'(rb));
    mark();
    send(1'b0, 2'b10, 1'b0, 12'h040, 32'h0);
    send(1'b0, 2'b00, 1'b1, 12'h010, 32'h0);
    idle(3);
    lit_count("t6", 2);
    lit("t6 mem kept", 0, 33'h0_12345678);
    lit("t6 byte kept", 1, 33'h0_000000EF);

    chk("drained a", 64'(hd[0]), 64'(exp_q.size()));
    chk("drained b", 64'(hd[1]), 64'(exp_q.size()));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_bytelane.md
Name: dmem_bytelane

Overview:
Parametrised successor to the word-only data memory. Holds a word array that is byte-addressable through little-endian byte lanes. Supports byte, half and word loads and stores, with sign or zero extension on loads. Replaces the combinational, tri-stated read with a registered, latency-configurable response channel. Flags misaligned or illegal accesses instead of silently corrupting memory. Sits between the CPU load/store stage and the memory array.

Parameters:
ADDR_W, 12, byte-address width; array depth = 2**(ADDR_W-2) words (default 1024)
READ_LAT, 1, request-to-response latency in cycles; legal values are 1 and 2
ERRCNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
ena  in  1  block enable; when low, no new request is accepted
req_valid  in  1  request present
req_ready  out  1  equals ena (combinational)
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  load zero-extends when 1; ignored for stores and word loads
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
rsp_valid  out  1  one-cycle pulse per accepted request
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  accepted request was misaligned or illegal
err_cnt  out  ERRCNT_W  saturating count of erroring requests

Behaviour:
- Request handshake: a request is accepted when req_valid && req_ready. One request can be accepted per cycle; there is no backpressure on the response side.
- Every accepted request produces exactly one response. rsp_valid is asserted exactly READ_LAT cycles after acceptance, and responses return in order.
- Word index is req_addr[ADDR_W-1:2]; byte lane is req_addr[1:0].
- Error rules:
  - size 01 with addr[0]=1 is an error.
  - size 10 with addr[1:0]!=0 is an error.
  - size 11 is an error.
  - On error: no array write, rsp_err=1, rsp_rdata=0, and err_cnt increments, saturating at all-ones.
- Store:
  - Byte-enable mask: byte = 1 lane; half = lanes {addr[1],0}+1..+0; word = 4'hF.
  - Data is shifted into the addressed lane(s); unselected bytes keep their old value.
  - The array is written on the acceptance edge.
  - The store response has rsp_err=0 and rsp_rdata=0.
- Load:
  - The array is read synchronously on the acceptance edge (stage 1).
  - The lane is extracted and extended, sign or zero per req_unsigned; size and lane are carried in the pipeline.
  - READ_LAT=2 adds one output register stage.
- Read-after-write: a load accepted in the cycle after a store to the same word returns the new data. A load and a store cannot be accepted in the same cycle because there is a single port.
- ena low:
  - req_ready=0.
  - Requests already in flight still complete and assert rsp_valid on schedule.
  - The array is not written.
- Reset (asynchronous, rst_n=0):
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, err_cnt=0.
  - All pipeline valid bits are cleared, so in-flight responses are dropped.
  - Array contents are not reset and are undefined at power-up.
  - Release is synchronous to clk; the first acceptance is possible on the first edge with rst_n=1.
- Outputs are never high-impedance; rsp_rdata is 0 whenever rsp_valid=0.

Decomposition:
- Shared package dmem_pkg:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - Function for the store lane mask.
  - Function for load extract/extend (lane, size, unsigned).
- Sub-module dmem_be_ram:
  - DEPTH x 32 synchronous single-port RAM with a 4-bit byte-write-enable and registered read.
  - No reset, so it can be inferred as block RAM.
- The top level holds the handshake, the error check, the response pipeline and err_cnt.

Test Plan:
1. Word store 0xDEADBEEF @0x010, then byte loads @0x010..0x013 signed -> 0xFFFFFFEF, 0xFFFFFFBE, 0xFFFFFFAD, 0xFFFFFFDE; the same loads unsigned -> 0x000000EF..0x000000DE; each response exactly READ_LAT cycles after acceptance.
2. Word 0x11223344 @0x020, then store half 0xABCD @0x022, then word load @0x020 -> 0xABCD3344; then byte store 0x55 @0x021, then word load -> 0xABCD5544.
3. Half load @0x021, word store @0x026, size 11 load @0x000 -> each gives rsp_err=1 and rdata=0; err_cnt=3; a following word load @0x024 shows memory unchanged.
4. Back-to-back: store 0x12345678 @0x040 in cycle N, load @0x040 in cycle N+1 -> 0x12345678; repeat with READ_LAT=2 and check that the pipelining order is preserved.
5. Accept three loads, then drop ena -> req_ready=0 the same cycle, all three rsp_valid pulses still appear; then a new req_valid with ena=0 -> no response.
6. Assert rst_n low with two loads in flight -> rsp_valid falls immediately, no stale response appears after release, err_cnt=0; memory data written before reset is still readable.
